// File: rtl/lambda_rec_func.sv
// lambda_rec_func: recursive-function unit for the lambda call framework.
// Evaluates f(n) = (n==0) ? BASE : n OP f(n-1) by pushing n, n-1, ... 1 onto an
// on-chip call-frame stack, then unwinding it and folding each frame into an
// accumulator. MODE selects OP/BASE: 0 gives sum 1..n, 1 gives n! (wrapping).
// Calls that would need more than DEPTH frames end with error=1 and result=0.
module lambda_rec_func #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int MODE  = 0,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             request,
  input  logic [WIDTH-1:0] args,
  output logic             busy,
  output logic             out,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [PTR_W-1:0] depth
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
  localparam logic [WIDTH-1:0] BASE = (MODE == 1) ? WIDTH'(1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    CALL,
    RET,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] sp, sp_next;
  logic [WIDTH-1:0] cur, cur_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] result_next;
  logic             out_next;
  logic             error_next;
  logic             push;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] combined;

  // The next free frame sits at sp; the most recently pushed frame sits at sp-1.
  assign push_idx = IDX_W'(sp);
  assign top_idx  = IDX_W'(sp - PTR_W'(1));
  assign top      = stack[top_idx];

  assign busy  = (state == CALL) || (state == RET);
  assign depth = sp;

  // Combine step used while unwinding; the product keeps only the low WIDTH bits.
  always_comb begin
    combined = '0;
    if (MODE == 1) begin
      combined = acc * top;
    end else begin
      combined = acc + top;
    end
  end

  // Next-state and datapath decisions for the call / unwind / finish sequence.
  always_comb begin
    state_next  = state;
    sp_next     = sp;
    cur_next    = cur;
    acc_next    = acc;
    result_next = result;
    out_next    = out;
    error_next  = error;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          cur_next   = args;
          sp_next    = '0;
          out_next   = 1'b0;
          error_next = 1'b0;
          state_next = CALL;
        end
      end
      CALL: begin
        if (cur != '0) begin
          if (sp < SP_FULL) begin
            push     = 1'b1;
            sp_next  = sp + PTR_W'(1);
            cur_next = cur - WIDTH'(1);
          end else begin
            out_next    = 1'b1;
            error_next  = 1'b1;
            result_next = '0;
            state_next  = DONE;
          end
        end else begin
          acc_next   = BASE;
          state_next = RET;
        end
      end
      RET: begin
        if (sp != '0) begin
          acc_next = combined;
          sp_next  = sp - PTR_W'(1);
        end else begin
          result_next = acc;
          out_next    = 1'b1;
          error_next  = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (!request) begin
          out_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control and datapath registers; reset wins over any call in progress.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      sp     <= '0;
      cur    <= '0;
      acc    <= '0;
      result <= '0;
      out    <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_next;
      sp     <= sp_next;
      cur    <= cur_next;
      acc    <= acc_next;
      result <= result_next;
      out    <= out_next;
      error  <= error_next;
    end
  end

  // Frame storage has no reset: only frames below sp are ever read back.
  always_ff @(posedge clock) begin
    if (push) begin
      stack[push_idx] <= cur;
    end
  end

endmodule

// File: tb/tb_lambda_rec_func.sv
// Testbench for lambda_rec_func: four instances cover sum mode, factorial mode,
// an 8-bit factorial and a shallow 4-frame stack, driven by directed calls.
module tb_lambda_rec_func;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req [4];
  logic [31:0] arg [4];

  logic        o0, e0, b0;
  logic [31:0] r0;
  logic [4:0]  d0;
  logic        o1, e1, b1;
  logic [31:0] r1;
  logic [4:0]  d1;
  logic        o2, e2, b2;
  logic [7:0]  r2;
  logic [4:0]  d2;
  logic        o3, e3, b3;
  logic [31:0] r3;
  logic [2:0]  d3;

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clock = ~clock;

  lambda_rec_func #(.WIDTH(32), .DEPTH(16), .MODE(0)) dutSum (
    .clock(clock), .reset_n(reset_n), .request(req[0]), .args(arg[0]),
    .busy(b0), .out(o0), .error(e0), .result(r0), .depth(d0));

  lambda_rec_func #(.WIDTH(32), .DEPTH(16), .MODE(1)) dutFact (
    .clock(clock), .reset_n(reset_n), .request(req[1]), .args(arg[1]),
    .busy(b1), .out(o1), .error(e1), .result(r1), .depth(d1));

  lambda_rec_func #(.WIDTH(8), .DEPTH(16), .MODE(1)) dutFact8 (
    .clock(clock), .reset_n(reset_n), .request(req[2]), .args(arg[2][7:0]),
    .busy(b2), .out(o2), .error(e2), .result(r2), .depth(d2));

  lambda_rec_func #(.WIDTH(32), .DEPTH(4), .MODE(0)) dutShallow (
    .clock(clock), .reset_n(reset_n), .request(req[3]), .args(arg[3]),
    .busy(b3), .out(o3), .error(e3), .result(r3), .depth(d3));

  function automatic logic readOut(input int id);
    case (id)
      0: return o0;
      1: return o1;
      2: return o2;
      default: return o3;
    endcase
  endfunction

  function automatic logic readErr(input int id);
    case (id)
      0: return e0;
      1: return e1;
      2: return e2;
      default: return e3;
    endcase
  endfunction

  function automatic logic readBusy(input int id);
    case (id)
      0: return b0;
      1: return b1;
      2: return b2;
      default: return b3;
    endcase
  endfunction

  function automatic logic [31:0] readRes(input int id);
    case (id)
      0: return r0;
      1: return r1;
      2: return {24'd0, r2};
      default: return r3;
    endcase
  endfunction

  function automatic logic [31:0] readDepth(input int id);
    case (id)
      0: return {27'd0, d0};
      1: return {27'd0, d1};
      2: return {27'd0, d2};
      default: return {29'd0, d3};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // One complete call: accept, wait for out, check latency/result/error/peak
  // depth, hold request through DONE, then drop it and check the release.
  task automatic applyStimulus(input int id, input logic [31:0] n, input int expLat,
                               input logic [31:0] expRes, input logic expErr,
                               input int expPeak, input bit toggle, input string tag);
    int cnt;
    int peak;
    logic [31:0] d;
    @(negedge clock);
    req[id] = 1'b1;
    arg[id] = n;
    @(posedge clock);
    #1;
    checkOutput({tag, "_busy"}, {31'd0, readBusy(id)}, 32'd1);
    cnt  = 0;
    peak = int'(readDepth(id));
    while (readOut(id) !== 1'b1 && cnt < 200) begin
      @(posedge clock);
      #1;
      cnt++;
      d = readDepth(id);
      if (int'(d) > peak) peak = int'(d);
      if (toggle) begin
        req[id] = (cnt < 4) ? ((cnt % 2) == 1 ? 1'b0 : 1'b1) : 1'b1;
        arg[id] = 32'd9;
      end
    end
    if (cnt >= 200) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    checkOutput({tag, "_lat"}, cnt, expLat);
    checkOutput({tag, "_res"}, readRes(id), expRes);
    checkOutput({tag, "_err"}, {31'd0, readErr(id)}, {31'd0, expErr});
    if (expPeak >= 0) checkOutput({tag, "_peak"}, peak, expPeak);
    req[id] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput({tag, "_hold_out"}, {31'd0, readOut(id)}, 32'd1);
    checkOutput({tag, "_hold_busy"}, {31'd0, readBusy(id)}, 32'd0);
    checkOutput({tag, "_hold_res"}, readRes(id), expRes);
    @(negedge clock);
    req[id] = 1'b0;
    @(posedge clock);
    #1;
    checkOutput({tag, "_drop_out"}, {31'd0, readOut(id)}, 32'd0);
    checkOutput({tag, "_kept_res"}, readRes(id), expRes);
    checkOutput({tag, "_kept_err"}, {31'd0, readErr(id)}, {31'd0, expErr});
    @(posedge clock);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0;
      arg[i] = 32'd0;
    end
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_out", {31'd0, o0}, 32'd0);
    checkOutput("rst_err", {31'd0, e0}, 32'd0);
    checkOutput("rst_res", r0, 32'd0);
    checkOutput("rst_busy", {31'd0, b0}, 32'd0);
    checkOutput("rst_depth", {27'd0, d0}, 32'd0);
    checkOutput("rst_out3", {31'd0, o3}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(0, 32'd4, 10, 32'd10, 1'b0, 4, 1'b0, "sum4");
    applyStimulus(1, 32'd5, 12, 32'd120, 1'b0, 5, 1'b0, "fact5");
    applyStimulus(1, 32'd0, 2, 32'd1, 1'b0, 0, 1'b0, "fact0");
    applyStimulus(0, 32'd0, 2, 32'd0, 1'b0, 0, 1'b0, "sum0");
    applyStimulus(2, 32'd6, 14, 32'd208, 1'b0, 6, 1'b0, "fact6w8");
    applyStimulus(3, 32'd4, 10, 32'd10, 1'b0, 4, 1'b0, "full4");
    applyStimulus(3, 32'd5, 5, 32'd0, 1'b1, 4, 1'b0, "ovf5");
    applyStimulus(3, 32'd2, 6, 32'd3, 1'b0, 2, 1'b0, "after_ovf");

    // Reset pulse while unwinding a call of 7: RET begins at accept+8, so two
    // edges later the stack pointer is 5.
    @(negedge clock);
    req[0] = 1'b1;
    arg[0] = 32'd7;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    checkOutput("midret_busy", {31'd0, b0}, 32'd1);
    checkOutput("midret_depth", {27'd0, d0}, 32'd5);
    @(negedge clock);
    reset_n = 1'b0;
    req[0]  = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst2_out", {31'd0, o0}, 32'd0);
    checkOutput("rst2_err", {31'd0, e0}, 32'd0);
    checkOutput("rst2_res", r0, 32'd0);
    checkOutput("rst2_busy", {31'd0, b0}, 32'd0);
    checkOutput("rst2_depth", {27'd0, d0}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(0, 32'd3, 8, 32'd6, 1'b0, 3, 1'b0, "sum3_after_rst");

    applyStimulus(1, 32'd3, 8, 32'd6, 1'b0, 3, 1'b0, "fact3");
    applyStimulus(1, 32'd4, 10, 32'd24, 1'b0, 4, 1'b1, "fact4_toggle");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
